// File: rtl/fp_mul_norm_pipe.sv
// Two-stage floating-point multiply back end: S1 classifies, sums exponents and normalizes; S2 rounds, range-checks and packs.
// Build option: define FP_MUL_ROUND_EN for round-to-nearest-even, otherwise results are truncated toward zero.
module fp_mul_norm_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [2*(MAN_W+1)-1:0] product,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    output logic                   flag_inv
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int P  = 2 * (MAN_W + 1);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX_S  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO_S = '0;
    localparam logic [EXP_W-1:0]     EXP_ONES   = '1;
    localparam logic [MAN_W-1:0]     QUIET_BIT  = {1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    function automatic logic [EXP_W-1:0] exp_field(input logic [W-1:0] x);
        return x[W-2 -: EXP_W];
    endfunction

    function automatic logic [MAN_W-1:0] man_field(input logic [W-1:0] x);
        return x[MAN_W-1:0];
    endfunction

    logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic                 s2_ready_s, s1_load_s, s2_load_s;
    cls_e                 s1_cls_q, s1_cls_d;
    logic                 s1_sign_q, s1_sign_d, s1_inv_q, s1_inv_d;
    logic signed [EW-1:0] s1_exp_q, s1_exp_d;
    logic [MAN_W-1:0]     s1_man_q, s1_man_d;
`ifdef FP_MUL_ROUND_EN
    logic                 s1_guard_q, s1_guard_d, s1_sticky_q, s1_sticky_d;
`else
    logic                 unused_low_s;
`endif
    logic [EXP_W-1:0]     ea_s, eb_s;
    logic [MAN_W-1:0]     ma_s, mb_s;
    logic                 a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
    logic [P-2:0]         norm_s;
    logic                 round_up_s, carry_s;
    logic [MAN_W-1:0]     man_rnd_s;
    logic signed [EW-1:0] exp_fin_s;
    logic [W-1:0]         result_q, result_d;
    logic                 flag_ovf_q, flag_ovf_d, flag_unf_q, flag_unf_d, flag_inv_q, flag_inv_d;

    assign s2_ready_s = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_ready_s;
    assign s1_load_s  = in_valid && in_ready;
    assign s2_load_s  = s1_valid_q && s2_ready_s;

    assign ea_s     = exp_field(a);
    assign eb_s     = exp_field(b);
    assign ma_s     = man_field(a);
    assign mb_s     = man_field(b);
    assign a_zero_s = (ea_s == {EXP_W{1'b0}});
    assign b_zero_s = (eb_s == {EXP_W{1'b0}});
    assign a_inf_s  = (ea_s == EXP_ONES) && (ma_s == {MAN_W{1'b0}});
    assign b_inf_s  = (eb_s == EXP_ONES) && (mb_s == {MAN_W{1'b0}});
    assign a_nan_s  = (ea_s == EXP_ONES) && (ma_s != {MAN_W{1'b0}});
    assign b_nan_s  = (eb_s == EXP_ONES) && (mb_s != {MAN_W{1'b0}});

    // Drop the leading one so the stored mantissa always starts just below it.
    assign norm_s = product[P-1] ? product[P-2:0] : {product[P-3:0], 1'b0};
`ifndef FP_MUL_ROUND_EN
    assign unused_low_s = ^norm_s[P-2-MAN_W:0];
`endif

    // Next state of both stage valid bits.
    always_comb begin
        if (s1_load_s) begin
            s1_valid_d = 1'b1;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage 1 next state: operand class, signed exponent sum and normalized mantissa.
    always_comb begin
        s1_cls_d    = s1_cls_q;
        s1_sign_d   = s1_sign_q;
        s1_inv_d    = s1_inv_q;
        s1_exp_d    = s1_exp_q;
        s1_man_d    = s1_man_q;
`ifdef FP_MUL_ROUND_EN
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
`endif
        if (s1_load_s) begin
            s1_cls_d  = CLS_NUM;
            s1_sign_d = a[W-1] ^ b[W-1];
            s1_inv_d  = 1'b0;
            s1_exp_d  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_S
                        + $signed({{(EW-1){1'b0}}, product[P-1]});
            s1_man_d  = norm_s[P-2 -: MAN_W];
`ifdef FP_MUL_ROUND_EN
            s1_guard_d  = norm_s[P-2-MAN_W];
            s1_sticky_d = |norm_s[P-3-MAN_W:0];
`endif
            if (a_nan_s) begin
                s1_cls_d  = CLS_NAN;
                s1_sign_d = a[W-1];
                s1_man_d  = ma_s | QUIET_BIT;
                s1_inv_d  = !ma_s[MAN_W-1];
            end else if (b_nan_s) begin
                s1_cls_d  = CLS_NAN;
                s1_sign_d = b[W-1];
                s1_man_d  = mb_s | QUIET_BIT;
                s1_inv_d  = !mb_s[MAN_W-1];
            end else if ((a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
                s1_cls_d  = CLS_NAN;
                s1_sign_d = 1'b0;
                s1_man_d  = QUIET_BIT;
                s1_inv_d  = 1'b1;
            end else if (a_inf_s || b_inf_s) begin
                s1_cls_d = CLS_INF;
            end else if (a_zero_s || b_zero_s) begin
                s1_cls_d = CLS_ZERO;
            end else begin
                s1_cls_d = CLS_NUM;
            end
        end else begin
            s1_cls_d = s1_cls_q;
        end
    end

    // Stage 2 next state: round, re-check range after any mantissa carry, and pack.
    always_comb begin
        result_d   = result_q;
        flag_ovf_d = flag_ovf_q;
        flag_unf_d = flag_unf_q;
        flag_inv_d = flag_inv_q;
`ifdef FP_MUL_ROUND_EN
        round_up_s = s1_guard_q && (s1_sticky_q || s1_man_q[0]);
`else
        round_up_s = 1'b0;
`endif
        {carry_s, man_rnd_s} = {1'b0, s1_man_q} + {{MAN_W{1'b0}}, round_up_s};
        exp_fin_s = s1_exp_q + $signed({{(EW-1){1'b0}}, carry_s});
        if (s2_load_s) begin
            flag_ovf_d = 1'b0;
            flag_unf_d = 1'b0;
            flag_inv_d = s1_inv_q;
            case (s1_cls_q)
                CLS_NAN:  result_d = {s1_sign_q, EXP_ONES, s1_man_q};
                CLS_INF:  result_d = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                CLS_ZERO: result_d = {s1_sign_q, {(W-1){1'b0}}};
                CLS_NUM: begin
                    if (exp_fin_s >= EXP_MAX_S) begin
                        result_d   = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                        flag_ovf_d = 1'b1;
                    end else if (exp_fin_s <= EXP_ZERO_S) begin
                        result_d   = {s1_sign_q, {(W-1){1'b0}}};
                        flag_unf_d = 1'b1;
                    end else begin
                        result_d = {s1_sign_q, exp_fin_s[EXP_W-1:0], man_rnd_s};
                    end
                end
                default: result_d = {W{1'b0}};
            endcase
        end else begin
            result_d = result_q;
        end
    end

    // Stage valid registers; reset discards any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage 1 payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cls_q    <= CLS_NUM;
            s1_sign_q   <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_exp_q    <= EXP_ZERO_S;
            s1_man_q    <= {MAN_W{1'b0}};
`ifdef FP_MUL_ROUND_EN
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
`endif
        end else begin
            s1_cls_q    <= s1_cls_d;
            s1_sign_q   <= s1_sign_d;
            s1_inv_q    <= s1_inv_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_q    <= s1_man_d;
`ifdef FP_MUL_ROUND_EN
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
`endif
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= {W{1'b0}};
            flag_ovf_q <= 1'b0;
            flag_unf_q <= 1'b0;
            flag_inv_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            flag_ovf_q <= flag_ovf_d;
            flag_unf_q <= flag_unf_d;
            flag_inv_q <= flag_inv_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flag_ovf  = flag_ovf_q;
    assign flag_unf  = flag_unf_q;
    assign flag_inv  = flag_inv_q;
endmodule

// File: tb/tb_fp_mul_norm_pipe.sv
// Randomized bench for fp_mul_norm_pipe: scoreboard against an arithmetic reference model plus directed corner vectors.
module tb_fp_mul_norm_pipe;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [47:0] product;
    logic        flag_ovf, flag_unf, flag_inv;

    int          n_checks = 0, n_fail = 0, n_in = 0, n_out = 0, stall_cycles = 0, ready_mode = 0;
    logic [34:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [34:0] prev_val;

    fp_mul_norm_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .product(product), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Result as {ovf, unf, inv, packed result}, from the arithmetic meaning of the operands.
    function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [47:0] p);
        int              ex, ey, e, sh;
        logic            sgn;
        logic [22:0]     mx, my;
        longint unsigned m;
`ifdef FP_MUL_ROUND_EN
        longint unsigned rem, half;
`endif
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        mx = x[22:0]; my = y[22:0];
        sgn = x[31] ^ y[31];
        if (ex == 255 && mx != 0) return {2'b00, !mx[22], x[31], 8'hFF, 1'b1, mx[21:0]};
        if (ey == 255 && my != 0) return {2'b00, !my[22], y[31], 8'hFF, 1'b1, my[21:0]};
        if ((ex == 255 && ey == 0) || (ex == 0 && ey == 255)) return {3'b001, 32'h7FC00000};
        if (ex == 255 || ey == 255) return {3'b000, sgn, 8'hFF, 23'd0};
        if (ex == 0 || ey == 0) return {3'b000, sgn, 31'd0};
        sh = p[47] ? 24 : 23;
        e  = ex + ey - 127 + (p[47] ? 1 : 0);
        m  = 64'(p) >> sh;
`ifdef FP_MUL_ROUND_EN
        rem  = 64'(p) & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && m[0])) m = m + 64'd1;
`endif
        if (m >= (64'd1 << 24)) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {3'b100, sgn, 8'hFF, 23'd0};
        if (e <= 0) return {3'b010, sgn, 31'd0};
        return {3'b000, sgn, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        m = 23'($urandom);
        case ($urandom_range(0, 9))
            0: e = 8'h00;
            1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = 23'd0; end
            2: e = 8'($urandom_range(1, 20));
            3: e = 8'($urandom_range(230, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, m};
    endfunction

    function automatic logic [47:0] rand_prod();
        logic [47:0] p;
        p = {16'($urandom), 32'($urandom)};
        if ($urandom_range(0, 7) == 0) p[45:0] = '1;
        if ($urandom_range(0, 7) == 1) p[23:0] = 24'h800000;
        if (!p[47]) p[46] = 1'b1;
        return p;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [47:0] p, input logic [34:0] e);
        int waits = 0;
        tick();
        in_valid = 1'b1; a = x; b = y; product = p;
        #2;
        while (!in_ready && waits < 100) begin
            waits++;
            tick();
            #2;
        end
        stall_cycles += waits;
        if (!in_ready) begin
            check_eq("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back(e);
            n_in++;
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            tick();
            w++;
        end
        repeat (3) tick();
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Downstream ready pattern for the free-running phases.
    always begin
        tick();
        if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else if (ready_mode == 0) out_ready = 1'b1;
    end

    // Output monitor, sampled just before the transfer edge.
    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_eq("hold", 64'({out_valid, flag_ovf, flag_unf, flag_inv, result}), 64'({1'b1, prev_val}));
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check_eq("result", 64'({flag_ovf, flag_unf, flag_inv, result}), 64'(exp_q.pop_front()));
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_val   = {flag_ovf, flag_unf, flag_inv, result};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y;
        logic [47:0] p;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; product = 48'd0;
        repeat (2) @(negedge clk);
        #3;
        check_eq("rst_state", 64'({out_valid, flag_ovf, flag_unf, flag_inv, result}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        #2;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        send(32'h3FC00000, 32'h3FC00000, 48'h900000000000, {3'b000, 32'h40100000});
        idle();
        #2;
        check_eq("lat_c1", 64'(out_valid), 64'd0);
        tick();
        #2;
        check_eq("lat_c2", 64'(out_valid), 64'd1);

        send(32'h7F800000, 32'h00000000, 48'h0, {3'b001, 32'h7FC00000});
        send(32'h7FC00001, 32'h3F800000, 48'h800000000000, {3'b000, 32'h7FC00001});
        send(32'h7F800001, 32'h3F800000, 48'h800000000000, {3'b001, 32'h7FC00001});
        send(32'h3F800000, 32'hFFC00005, 48'h800000000000, {3'b000, 32'hFFC00005});
        send(32'h7F000000, 32'h7F000000, 48'h800000000000, {3'b100, 32'h7F800000});
        send(32'h00800000, 32'h00800000, 48'h400000000000, {3'b010, 32'h00000000});
        send(32'h80800000, 32'h00800000, 48'h400000000000, {3'b010, 32'h80000000});
        send(32'h3F800001, 32'h3F800001, 48'h400001000001, {3'b000, 32'h3F800002});
        send(32'hFF800000, 32'h3F800000, 48'h800000000000, {3'b000, 32'hFF800000});
        send(32'h00000000, 32'hBF800000, 48'h400000000000, {3'b000, 32'h80000000});
        send(32'h00000001, 32'h3F800000, 48'h400000000000, {3'b000, 32'h00000000});
`ifdef FP_MUL_ROUND_EN
        send(32'h3F800000, 32'h3F800000, 48'h400000C00000, {3'b000, 32'h3F800002});
        send(32'h5F000000, 32'h5F800000, 48'h7FFFFFFFFFFF, {3'b100, 32'h7F800000});
`else
        send(32'h3F800000, 32'h3F800000, 48'h400000C00000, {3'b000, 32'h3F800001});
        send(32'h5F000000, 32'h5F800000, 48'h7FFFFFFFFFFF, {3'b000, 32'h7F7FFFFF});
`endif
        idle();
        drain();

        stall_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            x = rand_op(); y = rand_op(); p = rand_prod();
            send(x, y, p, ref_mul(x, y, p));
        end
        idle();
        check_eq("throughput", 64'(stall_cycles), 64'd0);
        drain();

        ready_mode = 2;
        out_ready  = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    x = rand_op(); y = rand_op(); p = rand_prod();
                    send(x, y, p, ref_mul(x, y, p));
                end
                idle();
            end
            begin
                for (int c = 0; c < 8; c++) begin
                    tick();
                    out_ready = !(c >= 3 && c <= 5);
                    if (c == 5) begin
                        #2;
                        check_eq("in_ready_full", 64'(in_ready), 64'd0);
                    end
                end
            end
        join
        ready_mode = 0;
        drain();

        x = rand_op(); y = rand_op(); p = rand_prod();
        send(x, y, p, ref_mul(x, y, p));
        x = rand_op(); y = rand_op(); p = rand_prod();
        send(x, y, p, ref_mul(x, y, p));
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid", 64'({out_valid, flag_ovf, flag_unf, flag_inv, result}), 64'd0);
        n_in -= exp_q.size();
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #2;
            check_eq("post_rst", 64'({in_ready, out_valid}), 64'b10);
        end

        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            x = rand_op(); y = rand_op(); p = rand_prod();
            send(x, y, p, ref_mul(x, y, p));
        end
        idle();
        ready_mode = 0;
        drain();
        check_eq("beat_count", 64'(n_out), 64'(n_in));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
